// File: rtl/exe_stage.sv
// exe_stage: execute stage. Latches the instruction issued by ID, evaluates the
// one-hot ALU operation (single-cycle multiply, 32-iteration restoring divide),
// issues the data-RAM request and feeds its in-flight result back to ID.
module exe_stage (
   input  logic         clk,
   input  logic         reset,
   input  logic         ID_to_EXE_valid,
   input  logic [160:0] ID_to_EXE_bus,
   output logic         EXE_allow_in,
   input  logic         MEM_allow_in,
   output logic         EXE_to_MEM_valid,
   output logic [78:0]  EXE_to_MEM_bus,
   output logic [39:0]  EXE_to_BY_bus,
   output logic         data_sram_en,
   output logic [3:0]   data_sram_we,
   output logic [31:0]  data_sram_addr,
   output logic [31:0]  data_sram_wdata
);
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

   // Two's-complement negate when neg is set; used to restore divider signs.
   function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                    input logic neg);
      return neg ? (~mag + 32'd1) : mag;
   endfunction

   logic                     valid_p0;
   logic [160:0]             bus_p0;

   logic [2:0]               valid_stage;
   logic                     rf_w_en;
   logic                     rf_w_data_sel;
   logic [1:0]               ram_wd;
   logic                     ram_we;
   logic                     ram_en;
   logic [DATA_W-1:0]        ram_wdata;
   logic [4:0]               rf_w_addr;
   logic [18:0]              alu_op;
   logic [DATA_W-1:0]        src1;
   logic [DATA_W-1:0]        src2;
   logic [DATA_W-1:0]        inst_pc;
   logic signed [DATA_W-1:0] src1_s;
   logic signed [DATA_W-1:0] src2_s;

   logic [63:0]              prod_u;
   logic [DATA_W-1:0]        mulh_res;
   logic [DATA_W-1:0]        alu_result;

   logic                     div_class;
   logic                     div_signed;
   logic [DATA_W-1:0]        dvd_mag;
   logic [DATA_W-1:0]        dvs_mag;
   div_state_t               div_state;
   logic [4:0]               div_cnt;
   logic [DATA_W-1:0]        quo;
   logic [DATA_W-1:0]        rem;
   logic [32:0]              rem_shift;
   logic [32:0]              rem_trial;
   logic [DATA_W-1:0]        quo_next;
   logic [DATA_W-1:0]        rem_next;
   logic [DATA_W-1:0]        div_quo;
   logic [DATA_W-1:0]        div_rem;

   logic                     ready_go;
   logic [3:0]               store_we;
   logic [DATA_W-1:0]        store_wdata;

   assign valid_stage   = bus_p0[160:158];
   assign rf_w_en       = bus_p0[157];
   assign rf_w_data_sel = bus_p0[156];
   assign ram_wd        = bus_p0[155:154];
   assign ram_we        = bus_p0[153];
   assign ram_en        = bus_p0[152];
   assign ram_wdata     = bus_p0[151:120];
   assign rf_w_addr     = bus_p0[119:115];
   assign alu_op        = bus_p0[114:96];
   assign src2          = bus_p0[95:64];
   assign src1          = bus_p0[63:32];
   assign inst_pc       = bus_p0[31:0];
   assign src1_s        = src1;
   assign src2_s        = src2;

   // Input register: take a new instruction only when the stage can accept it.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_p0 <= 1'b0;
         bus_p0   <= '0;
      end else begin
         if (EXE_allow_in) valid_p0 <= ID_to_EXE_valid;
         if (ID_to_EXE_valid && EXE_allow_in) bus_p0 <= ID_to_EXE_bus;
      end
   end

   // One unsigned multiplier; the signed high word is corrected from it.
   assign prod_u   = {32'd0, src1} * {32'd0, src2};
   assign mulh_res = prod_u[63:32] - (src1[31] ? src2 : 32'd0)
                                   - (src2[31] ? src1 : 32'd0);

   // ALU: one-hot op select, results OR-ed so an empty op yields zero.
   always_comb begin
      alu_result = '0;
      if (alu_op[0])  alu_result = alu_result | (src1 + src2);
      if (alu_op[1])  alu_result = alu_result | (src1 - src2);
      if (alu_op[2])  alu_result = alu_result | {31'd0, src1_s < src2_s};
      if (alu_op[3])  alu_result = alu_result | {31'd0, src1 < src2};
      if (alu_op[4])  alu_result = alu_result | (src1 & src2);
      if (alu_op[5])  alu_result = alu_result | ~(src1 | src2);
      if (alu_op[6])  alu_result = alu_result | (src1 | src2);
      if (alu_op[7])  alu_result = alu_result | (src1 ^ src2);
      if (alu_op[8])  alu_result = alu_result | (src1 << src2[4:0]);
      if (alu_op[9])  alu_result = alu_result | (src1 >> src2[4:0]);
      if (alu_op[10]) alu_result = alu_result | DATA_W'(src1_s >>> src2[4:0]);
      if (alu_op[11]) alu_result = alu_result | src2;
      if (alu_op[12]) alu_result = alu_result | prod_u[31:0];
      if (alu_op[13]) alu_result = alu_result | mulh_res;
      if (alu_op[14]) alu_result = alu_result | prod_u[63:32];
      if (alu_op[15]) alu_result = alu_result | div_quo;
      if (alu_op[16]) alu_result = alu_result | div_rem;
      if (alu_op[17]) alu_result = alu_result | div_quo;
      if (alu_op[18]) alu_result = alu_result | div_rem;
   end

   assign div_class  = |alu_op[18:15];
   assign div_signed = alu_op[15] | alu_op[16];
   assign dvd_mag    = apply_sign(src1, div_signed & src1[31]);
   assign dvs_mag    = apply_sign(src2, div_signed & src2[31]);

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_shift = {rem, quo[31]};
      rem_trial = rem_shift - {1'b0, dvs_mag};
      if (!rem_trial[32]) begin
         rem_next = rem_trial[31:0];
         quo_next = {quo[30:0], 1'b1};
      end else begin
         rem_next = rem_shift[31:0];
         quo_next = {quo[30:0], 1'b0};
      end
   end

   // Divider FSM: start only from IDLE, 32 iterations, hold DONE until the instruction leaves.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_state <= DIV_IDLE;
         div_cnt   <= '0;
      end else begin
         case (div_state)
            DIV_IDLE: begin
               if (valid_p0 && div_class) begin
                  div_state <= DIV_BUSY;
                  div_cnt   <= '0;
                  quo       <= dvd_mag;
                  rem       <= '0;
               end
            end
            DIV_BUSY: begin
               quo     <= quo_next;
               rem     <= rem_next;
               div_cnt <= div_cnt + 5'd1;
               if (div_cnt == 5'd31) div_state <= DIV_DONE;
            end
            DIV_DONE: begin
               if (EXE_to_MEM_valid && MEM_allow_in) div_state <= DIV_IDLE;
            end
            default: div_state <= DIV_IDLE;
         endcase
      end
   end

   // Zero divisor overrides the sign fix-up; signed overflow falls out naturally.
   assign div_quo = (src2 == 32'd0) ? 32'hFFFF_FFFF
                                    : apply_sign(quo, div_signed & (src1[31] ^ src2[31]));
   assign div_rem = (src2 == 32'd0) ? src1 : apply_sign(rem, div_signed & src1[31]);

   assign ready_go         = ~div_class | (div_state == DIV_DONE);
   assign EXE_allow_in     = ~valid_p0 | (ready_go & MEM_allow_in);
   assign EXE_to_MEM_valid = valid_p0 & ready_go;

   // Store lane enables and data replication by access width.
   always_comb begin
      store_we    = 4'b1111;
      store_wdata = ram_wdata;
      case (ram_wd)
         2'b01: begin
            store_we    = 4'b0001 << alu_result[1:0];
            store_wdata = {4{ram_wdata[7:0]}};
         end
         2'b10: begin
            store_we    = 4'b0011 << {alu_result[1], 1'b0};
            store_wdata = {2{ram_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign data_sram_en    = valid_p0 & ram_en & ready_go & MEM_allow_in;
   assign data_sram_we    = (valid_p0 & ram_we) ? store_we : 4'b0000;
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = store_wdata;

   assign EXE_to_MEM_bus = {valid_stage, rf_w_en, rf_w_data_sel, ram_en, ram_wd,
                            alu_result[1:0], rf_w_addr, alu_result, inst_pc};

   assign EXE_to_BY_bus  = {rf_w_addr, alu_result, valid_stage[0] & ready_go,
                            valid_p0, rf_w_en & valid_p0};
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed bench for exe_stage with a result scoreboard.
module tb_exe_stage;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         id_valid = 1'b0;
   logic [160:0] id_bus = '0;
   logic         allow_in;
   logic         mem_allow = 1'b1;
   logic         out_valid;
   logic [78:0]  mem_bus;
   logic [39:0]  by_bus;
   logic         sram_en;
   logic [3:0]   sram_we;
   logic [31:0]  sram_addr;
   logic [31:0]  sram_wdata;

   int           n_assert = 0;
   int           n_fail = 0;
   logic [31:0]  sb[$];
   logic [31:0]  pc = 32'h0000_1000;

   always #5 clk = ~clk;

   exe_stage dut (
      .clk              (clk),
      .reset            (reset),
      .ID_to_EXE_valid  (id_valid),
      .ID_to_EXE_bus    (id_bus),
      .EXE_allow_in     (allow_in),
      .MEM_allow_in     (mem_allow),
      .EXE_to_MEM_valid (out_valid),
      .EXE_to_MEM_bus   (mem_bus),
      .EXE_to_BY_bus    (by_bus),
      .data_sram_en     (sram_en),
      .data_sram_we     (sram_we),
      .data_sram_addr   (sram_addr),
      .data_sram_wdata  (sram_wdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [18:0] onehot(input int k);
      return (k < 0) ? 19'd0 : (19'd1 << k);
   endfunction

   function automatic logic [160:0] mk(input logic [2:0] vs, input logic wen,
                                       input logic [1:0] wd, input logic we,
                                       input logic en, input logic [31:0] wdata,
                                       input logic [4:0] waddr, input logic [18:0] op,
                                       input logic [31:0] s2, input logic [31:0] s1,
                                       input logic [31:0] ipc);
      return {vs, wen, 1'b0, wd, we, en, wdata, waddr, op, s2, s1, ipc};
   endfunction

   // Reference ALU from the arithmetic definitions.
   function automatic logic [31:0] model(input int k, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] as, bs;
      logic signed [63:0] ae, be, ps;
      logic [63:0]        pu;
      as = a; bs = b; ae = as; be = bs;
      ps = ae * be;
      pu = {32'd0, a} * {32'd0, b};
      case (k)
         0:  return a + b;
         1:  return a - b;
         2:  return (as < bs) ? 32'd1 : 32'd0;
         3:  return (a < b) ? 32'd1 : 32'd0;
         4:  return a & b;
         5:  return ~(a | b);
         6:  return a | b;
         7:  return a ^ b;
         8:  return a << b[4:0];
         9:  return a >> b[4:0];
         10: return 32'(as >>> b[4:0]);
         11: return b;
         12: return pu[31:0];
         13: return ps[63:32];
         14: return pu[63:32];
         15: if (b == 0) return 32'hFFFF_FFFF;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
             else return 32'(as / bs);
         16: if (b == 0) return a;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
             else return 32'(as % bs);
         17: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         18: return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   // Present an instruction, wait for acceptance, return at the negedge after it.
   task automatic issue(input logic [160:0] b);
      int guard = 0;
      id_bus   = b;
      id_valid = 1'b1;
      while (!allow_in && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("accept_wait", 32'(guard < 100), 32'd1);
      @(posedge clk);
      @(negedge clk);
      id_valid = 1'b0;
      pc = pc + 32'd4;
   endtask

   // Run one register-writing op; check latency, stall, result, bypass, hold and drain.
   task automatic run_op(input string tag, input int k, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input int hold);
      logic [31:0] expv;
      int          lat = 0;
      logic        stall_ok = 1'b1;
      sb.push_back(model(k, a, b));
      issue(mk(3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0, 5'd9, onehot(k), b, a, pc));
      while (!out_valid && lat < 100) begin
         if (allow_in || by_bus[2]) stall_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
      expv = sb.pop_front();
      check({tag, "_res"}, mem_bus[63:32], expv);
      check({tag, "_bypass"}, by_bus[34:3], expv);
      check({tag, "_wdv"}, {31'd0, by_bus[2]}, 32'd1);
      mem_allow = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_vld"}, {31'd0, out_valid}, 32'd1);
         check({tag, "_hold_res"}, mem_bus[63:32], expv);
      end
      mem_allow = 1'b1;
      @(negedge clk);
      check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [78:0] snap;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_allow", {31'd0, allow_in}, 32'd1);
      check("rst_outvld", {31'd0, out_valid}, 32'd0);
      check("rst_sram_en", {31'd0, sram_en}, 32'd0);
      check("rst_sram_we", {28'd0, sram_we}, 32'd0);
      check("rst_byp_wen", {31'd0, by_bus[0]}, 32'd0);
      check("rst_byp_vld", {31'd0, by_bus[1]}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // ALU ops, single cycle
      run_op("add",   0,  32'd5,          32'd7,          0, 0);
      run_op("sub",   1,  32'd3,          32'd5,          0, 0);
      run_op("slt",   2,  32'hFFFF_FFFF,  32'd1,          0, 0);
      run_op("sltu",  3,  32'hFFFF_FFFF,  32'd1,          0, 0);
      run_op("nor",   5,  32'h0F0F_0000,  32'h0000_00F0,  0, 0);
      run_op("xor",   7,  32'hAAAA_5555,  32'hFFFF_0000,  0, 0);
      run_op("sll",   8,  32'h0000_0003,  32'h0000_0024,  0, 0);
      run_op("srl",   9,  32'h8000_0000,  32'd4,          0, 0);
      run_op("sra",   10, 32'h8000_0000,  32'd4,          0, 0);
      run_op("lui",   11, 32'h1234_5678,  32'hABCD_0000,  0, 0);
      run_op("mul",   12, 32'hFFFF_FFFF,  32'd3,          0, 0);
      run_op("mulh",  13, 32'hFFFF_FFFF,  32'd3,          0, 0);
      run_op("mulhu", 14, 32'hFFFF_FFFF,  32'd3,          0, 0);
      run_op("mulhn", 13, 32'h8000_0000,  32'h8000_0000,  0, 0);
      run_op("noop",  -1, 32'd5,          32'd7,          0, 0);

      // Divides: 33-cycle latency, hold in DONE must not restart
      run_op("divu",  17, 32'd100,        32'd7,          33, 0);
      run_op("modu",  18, 32'd100,        32'd7,          33, 3);
      run_op("divov", 15, 32'h8000_0000,  32'hFFFF_FFFF,  33, 0);
      run_op("modov", 16, 32'h8000_0000,  32'hFFFF_FFFF,  33, 0);
      run_op("div0",  15, 32'd9,          32'd0,          33, 0);
      run_op("mod0",  16, 32'd9,          32'd0,          33, 0);
      run_op("modng", 16, 32'hFFFF_FFF9,  32'd2,          33, 0);
      run_op("divng", 15, 32'hFFFF_FFF9,  32'd2,          33, 0);
      run_op("divub", 17, 32'hFFFF_FFFF,  32'd3,          33, 0);

      // Byte store to 0x1003
      sb.push_back(32'h0000_1003);
      issue(mk(3'b000, 1'b0, 2'b01, 1'b1, 1'b1, 32'h0000_00AB, 5'd0, onehot(0),
               32'd3, 32'h0000_1000, pc));
      check("stb_en", {31'd0, sram_en}, 32'd1);
      check("stb_we", {28'd0, sram_we}, 32'h8);
      check("stb_wdata", sram_wdata, 32'hABAB_ABAB);
      check("stb_addr", sram_addr, sb.pop_front());
      check("stb_byp_wen", {31'd0, by_bus[0]}, 32'd0);
      @(negedge clk);
      check("stb_once", {31'd0, sram_en}, 32'd0);

      // Half store to 0x1002
      sb.push_back(32'h0000_1002);
      issue(mk(3'b000, 1'b0, 2'b10, 1'b1, 1'b1, 32'h0000_1234, 5'd0, onehot(0),
               32'd2, 32'h0000_1000, pc));
      check("sth_en", {31'd0, sram_en}, 32'd1);
      check("sth_we", {28'd0, sram_we}, 32'hC);
      check("sth_wdata", sram_wdata, 32'h1234_1234);
      check("sth_addr", sram_addr, sb.pop_front());
      @(negedge clk);
      check("sth_once", {31'd0, sram_en}, 32'd0);

      // Word load with MEM stalled for three cycles
      sb.push_back(32'h0000_2004);
      mem_allow = 1'b0;
      issue(mk(3'b100, 1'b1, 2'b00, 1'b0, 1'b1, 32'd0, 5'd7, onehot(0),
               32'd4, 32'h0000_2000, pc));
      check("ldw_outvld", {31'd0, out_valid}, 32'd1);
      check("ldw_wdv", {31'd0, by_bus[2]}, 32'd0);
      check("ldw_byp_wen", {31'd0, by_bus[0]}, 32'd1);
      check("ldw_stall_en", {31'd0, sram_en}, 32'd0);
      snap = mem_bus;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ldw_hold_en", {31'd0, sram_en}, 32'd0);
         check("ldw_hold_bus", {31'd0, mem_bus === snap}, 32'd1);
         check("ldw_hold_allow", {31'd0, allow_in}, 32'd0);
      end
      mem_allow = 1'b1;
      #1;
      check("ldw_en", {31'd0, sram_en}, 32'd1);
      check("ldw_we", {28'd0, sram_we}, 32'd0);
      check("ldw_addr", sram_addr, sb.pop_front());
      @(negedge clk);
      check("ldw_once", {31'd0, sram_en}, 32'd0);

      // Reset in the middle of a divide discards it
      issue(mk(3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0, 5'd9, onehot(17),
               32'd7, 32'd100, pc));
      repeat (10) @(negedge clk);
      check("busy_allow", {31'd0, allow_in}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("rstbusy_vld", {31'd0, by_bus[1]}, 32'd0);
      check("rstbusy_allow", {31'd0, allow_in}, 32'd1);
      check("rstbusy_outvld", {31'd0, out_valid}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      run_op("divu_after", 17, 32'd100, 32'd7, 33, 0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
